// File: rtl/train_sequencer_pkg.sv
// Shared neural-network definitions: phase period, sample count and the
// training sequencer's state encoding.
package train_sequencer_pkg;

    localparam int NN_N  = 13;
    localparam int NN_S  = 4;
    localparam int NN_AW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // The renewal counter sticks at its maximum instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/train_sequencer.sv
// Training-run sequencer: a load_kt strobe follows each phase 0, and a weight
// commit plus a sample advance follow each phase N-1, until renewals are done.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int N  = NN_N,
    parameter int S  = NN_S,
    parameter int AW = NN_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    phase,
    input  logic          finish_updating,
    input  logic          done_ack,
    output logic [AW-1:0] sample_addr,
    output logic          load_kt,
    output logic          w_update_en,
    output logic          busy,
    output logic          done,
    output logic [15:0]   upd_count,
    output logic          err
);

    localparam logic [4:0]    PHASE_LIMIT = 5'(N);
    localparam logic [3:0]    PHASE_LAST  = 4'(N - 1);
    localparam logic [AW-1:0] ADDR_LAST   = AW'(S - 1);

    seq_state_t state;

    logic phase_bad;
    assign phase_bad = ({1'b0, phase} >= PHASE_LIMIT);

    // finish_updating wins over every strobe; an out-of-range phase issues none.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sample_addr <= '0;
            upd_count   <= '0;
            load_kt     <= 1'b0;
            w_update_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            load_kt     <= 1'b0;
            w_update_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !finish_updating) begin
                        state       <= ST_TRAIN;
                        sample_addr <= '0;
                        upd_count   <= '0;
                        busy        <= 1'b1;
                    end
                end
                ST_TRAIN: begin
                    if (phase_bad) begin
                        err <= 1'b1;
                    end
                    if (finish_updating) begin
                        state <= ST_DRAIN;
                    end else if (phase_bad) begin
                        state <= ST_TRAIN;
                    end else if (phase == 4'd0) begin
                        load_kt <= 1'b1;
                    end else if (phase == PHASE_LAST) begin
                        w_update_en <= 1'b1;
                        sample_addr <= (sample_addr == ADDR_LAST) ? '0 : sample_addr + 1'b1;
                        upd_count   <= sat_inc16(upd_count);
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    if (done_ack) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: a behavioural run model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_train_sequencer;

    localparam int N  = 13;
    localparam int S  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    phase = 4'd0;
    logic          finish_updating = 1'b0;
    logic          done_ack = 1'b0;
    logic [AW-1:0] sample_addr;
    logic          load_kt;
    logic          w_update_en;
    logic          busy;
    logic          done;
    logic [15:0]   upd_count;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    train_sequencer #(.N(N), .S(S), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .phase           (phase),
        .finish_updating (finish_updating),
        .done_ack        (done_ack),
        .sample_addr     (sample_addr),
        .load_kt         (load_kt),
        .w_update_en     (w_update_en),
        .busy            (busy),
        .done            (done),
        .upd_count       (upd_count),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Run model: a run is "training", then one drain cycle, then waiting for ack.
    bit training = 0;
    bit draining = 0;
    bit waiting  = 0;
    int m_addr   = 0;
    int m_count  = 0;
    bit m_load   = 0;
    bit m_upd    = 0;
    bit m_err    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            training = 0; draining = 0; waiting = 0;
            m_addr = 0; m_count = 0; m_load = 0; m_upd = 0; m_err = 0;
        end else begin
            m_load = 0;
            m_upd  = 0;
            if (training) begin
                if (int'(phase) >= N) m_err = 1;
                if (finish_updating) begin
                    training = 0;
                    draining = 1;
                end else if (int'(phase) == 0) begin
                    m_load = 1;
                end else if (int'(phase) == N - 1) begin
                    m_upd   = 1;
                    m_addr  = (m_addr + 1) % S;
                    m_count = (m_count < 65535) ? m_count + 1 : m_count;
                end
            end else if (draining) begin
                draining = 0;
                waiting  = 1;
            end else if (waiting) begin
                if (done_ack) waiting = 0;
            end else if (start && !finish_updating) begin
                training = 1;
                m_addr   = 0;
                m_count  = 0;
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("model.sample_addr", int'(sample_addr), m_addr);
        check_output("model.upd_count",   int'(upd_count),   m_count);
        check_output("model.load_kt",     int'(load_kt),     int'(m_load));
        check_output("model.w_update_en", int'(w_update_en), int'(m_upd));
        check_output("model.busy",        int'(busy),        int'(training || draining));
        check_output("model.done",        int'(done),        int'(waiting));
        check_output("model.err",         int'(err),         int'(m_err));
        check_output("model.strobe_excl", int'(load_kt && w_update_en), 0);
    end

    task automatic apply_stimulus(input int ph, input bit st, input bit fu, input bit ack);
        phase           = 4'(ph);
        start           = st;
        finish_updating = fu;
        done_ack        = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic run_periods(input int count);
        for (int r = 0; r < count; r++)
            for (int p = 0; p < N; p++)
                apply_stimulus(p, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".sample_addr"}, int'(sample_addr), 0);
        check_output({tag, ".upd_count"},   int'(upd_count),   0);
        check_output({tag, ".load_kt"},     int'(load_kt),     0);
        check_output({tag, ".w_update_en"}, int'(w_update_en), 0);
        check_output({tag, ".busy"},        int'(busy),        0);
        check_output({tag, ".done"},        int'(done),        0);
        check_output({tag, ".err"},         int'(err),         0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #20;
        check_all_zero("reset");
        @(negedge clk);
        #1 reset = 1'b0;

        // Basic run: five renewals, address wraps after four.
        apply_stimulus(0, 1, 0, 0);
        check_output("start.busy", int'(busy), 1);
        apply_stimulus(0, 0, 0, 0);
        check_output("first.load_kt", int'(load_kt), 1);
        for (int p = 1; p < N; p++) apply_stimulus(p, 0, 0, 0);
        check_output("first.w_update_en", int'(w_update_en), 1);
        check_output("first.sample_addr", int'(sample_addr), 1);
        run_periods(3);
        check_output("wrap.sample_addr", int'(sample_addr), 0);
        run_periods(1);
        check_output("five.sample_addr", int'(sample_addr), 1);
        check_output("five.upd_count", int'(upd_count), 5);
        apply_stimulus(5, 0, 1, 0);
        check_output("drain.busy", int'(busy), 1);
        check_output("drain.done", int'(done), 0);
        apply_stimulus(5, 1, 1, 0);
        check_output("done.busy", int'(busy), 0);
        check_output("done.done", int'(done), 1);
        apply_stimulus(5, 0, 0, 0);
        check_output("done.hold", int'(done), 1);
        apply_stimulus(5, 0, 0, 1);
        check_output("ack.done", int'(done), 0);
        check_output("ack.upd_count", int'(upd_count), 5);

        // Start while renewals are already finished is ignored.
        apply_stimulus(0, 1, 1, 0);
        check_output("blocked.busy", int'(busy), 0);
        check_output("blocked.upd_count", int'(upd_count), 5);

        // Start inside TRAIN, then finish on the same edge as phase N-1.
        apply_stimulus(0, 1, 0, 0);
        check_output("restart.upd_count", int'(upd_count), 0);
        run_periods(2);
        apply_stimulus(3, 1, 0, 0);
        check_output("restart_in_train.sample_addr", int'(sample_addr), 2);
        check_output("restart_in_train.upd_count", int'(upd_count), 2);
        for (int p = 4; p < N - 1; p++) apply_stimulus(p, 0, 0, 0);
        apply_stimulus(N - 1, 0, 1, 0);
        check_output("finish_prio.w_update_en", int'(w_update_en), 0);
        check_output("finish_prio.sample_addr", int'(sample_addr), 2);
        check_output("finish_prio.busy", int'(busy), 1);
        apply_stimulus(0, 0, 1, 0);
        check_output("finish_prio.done", int'(done), 1);
        apply_stimulus(0, 0, 0, 1);

        // Out-of-range phase raises a sticky error with no strobe.
        apply_stimulus(0, 1, 0, 0);
        apply_stimulus(14, 0, 0, 0);
        check_output("bad_phase.err", int'(err), 1);
        check_output("bad_phase.load_kt", int'(load_kt), 0);
        check_output("bad_phase.w_update_en", int'(w_update_en), 0);
        apply_stimulus(0, 0, 0, 0);
        check_output("after_bad.load_kt", int'(load_kt), 1);
        apply_stimulus(0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        check_output("sticky.err", int'(err), 1);
        check_output("sticky.done", int'(done), 0);

        // Asynchronous reset in the middle of a run.
        apply_stimulus(0, 1, 0, 0);
        for (int p = 0; p < 6; p++) apply_stimulus(p, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        #1 reset = 1'b0;
        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(12, 0, 0, 0);
        check_output("post_reset.busy", int'(busy), 0);
        apply_stimulus(0, 1, 0, 0);
        check_output("post_reset.start_addr", int'(sample_addr), 0);
        run_periods(1);
        check_output("post_reset.sample_addr", int'(sample_addr), 1);
        check_output("post_reset.upd_count", int'(upd_count), 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
